prio_encoder_ctrl: RTL and testbench
====================================

Name: prio_encoder_ctrl

Overview:
Registered priority encoder with request latching and a valid/ack handshake. It is the counterpart of the team's n-to-2^n line decoders. It captures rising edges on N request lines and holds them as pending events. It then presents the W-bit index of the highest-priority unmasked pending line to a consumer, which acknowledges each code in turn. It sits between raw event sources, such as the outputs of a decoder-driven select bus, and a controller that services one event at a time.

Parameters:
N, 8, number of request lines (2..16)
W, 3, code width; must equal ceil(log2(N))

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_i  in  N  request lines, active high, level; an event is a 0->1 transition
mask_i  in  N  1 = line not eligible for presentation (still latched)
ack_i  in  1  consumer accepts the presented code
clr_ovf_i  in  1  clears ovf_o
code_o  out  W  index of the presented line
valid_o  out  1  code_o is meaningful
pend_o  out  N  pending register (registered)
ovf_o  out  1  sticky: an event arrived on an already-pending line

Behaviour:
- Reset (async, rst_n=0): code_o=0, valid_o=0, pend_o=0, ovf_o=0, req_q=all ones, state=IDLE.
  - req_q=all ones means a line held high through reset is not counted as an event.
  - Reset asserted mid-handshake drops valid_o immediately; the pending event is lost.
- Edge detect: rise = req_i & ~req_q; req_q <= req_i every cycle.
- Pending update each clock: pend <= (pend & ~clr) | rise.
  - clr is the one-hot of code_o when valid_o & ack_i, otherwise 0.
  - A rise on the line being cleared in the same cycle wins: the bit stays set, no overflow.
- Overflow: a rise on a bit that is already pending and not being cleared sets ovf_o.
  - clr_ovf_i clears ovf_o.
  - Set and clear in the same cycle: set wins.
- Eligibility: elig = pend & ~mask_i. Highest index has highest priority.
- FSM:
  - IDLE: if elig != 0, load code_o = index of highest set bit of elig, set valid_o=1, go to PRESENT. Otherwise stay, valid_o=0.
  - PRESENT: code_o and valid_o held stable regardless of mask_i, pend or new events, until ack_i=1. On ack: clear that pend bit, valid_o=0, go to IDLE.
- Latency:
  - req_i first sampled high at edge T: pend bit set after T; valid_o high after T+1 (2 cycles).
  - After ack at edge A, valid_o is low for exactly one cycle; the next code can be valid after A+1.
  - Sustained throughput is one code per 2 cycles.
- ack_i while valid_o=0 is ignored.
- A line held high produces only one event; it must return to 0 before it can generate another.
- If a masked line becomes unmasked while pending, it is eligible on the next IDLE evaluation.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PRESENT);
  - constant defaults N=8, W=3;
  - function onehot(code) returning an N-bit vector.
- One natural sub-module: prio_enc_comb.
  - Purely combinational N->W highest-index priority encoder with a found flag.
  - Built from the library's and/or/not gate primitives.
  - Instantiated once on elig.

Test Plan:
- Reset release with req_i=8'h04 held, then idle 5 cycles -> valid_o stays 0, pend_o=0.
- Pulse req_i bit 5 one cycle at edge T -> pend_o=8'h20 after T, valid_o=1 and code_o=5 after T+1; ack one cycle -> pend_o=0, valid_o=0.
- Rise bits 1, 6 and 3 in the same cycle, then ack every time valid_o=1 -> codes 6, 3, 1 in order, with one valid-low cycle between each.
- mask_i=8'h80, rise bits 7 and 2 -> code 2 presented; clear mask while code 2 is presented -> code_o stays 2 until ack, then code 7.
- Re-pulse bit 4 while it is pending and not presented -> ovf_o=1, sticky until clr_ovf_i; re-pulse bit 4 in its ack cycle -> ovf_o unchanged, pend bit 4 still set, code 4 re-presented.
- Drop rst_n asynchronously between clock edges while valid_o=1 -> valid_o, pend_o and code_o go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/prio_encoder_ctrl_pkg.sv
// Shared types and helpers for the registered priority encoder controller.
package prio_encoder_ctrl_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;
  localparam int N_MAX = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Sized for the widest supported configuration; callers truncate to N.
  function automatic logic [N_MAX-1:0] onehot(input logic [3:0] code);
    return N_MAX'(1) << code;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-index-wins priority encoder built from gate primitives.
module prio_enc_comb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_code,
  output logic         o_found
);

  // Per-bit scopes keep the OR chain in separate nets rather than one vector.
  for (genvar i = N - 1; i >= 0; i--) begin : g_bit
    logic w_hi;
    logic w_hi_n;
    logic w_sel;
    logic w_any;
    if (i == N - 1) begin : g_top
      assign w_hi = 1'b0;
    end else begin : g_chain
      assign w_hi = g_bit[i+1].w_any;
    end
    or  u_any (w_any, w_hi, i_req[i]);
    not u_inv (w_hi_n, w_hi);
    and u_sel (w_sel, i_req[i], w_hi_n);
  end

  assign o_found = g_bit[0].w_any;

  // Code bit b is the OR of every one-hot select whose index has bit b set.
  for (genvar b = 0; b < W; b++) begin : g_code
    for (genvar i = 0; i < N; i++) begin : g_i
      logic w_prev;
      logic w_acc;
      if (i == 0) begin : g_base
        assign w_prev = 1'b0;
      end else begin : g_link
        assign w_prev = g_i[i-1].w_acc;
      end
      if (((i >> b) & 1) == 1) begin : g_use
        or u_acc (w_acc, w_prev, g_bit[i].w_sel);
      end else begin : g_skip
        assign w_acc = w_prev;
      end
    end
    assign o_code[b] = g_i[N-1].w_acc;
  end

endmodule

// File: rtl/prio_encoder_ctrl.sv
// Latches request rising edges as pending events and presents the highest
// eligible index to a consumer over a valid/ack handshake.
module prio_encoder_ctrl
  import prio_encoder_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         ack_i,
  input  logic         clr_ovf_i,
  output logic [W-1:0] code_o,
  output logic         valid_o,
  output logic [N-1:0] pend_o,
  output logic         ovf_o
);

  logic [N-1:0] r_req_q;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_code;
  logic         r_valid;
  logic         r_ovf;
  state_e       r_state;

  logic [N-1:0] w_rise;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_elig;
  logic [W-1:0] w_enc;
  logic         w_found;
  logic         w_ack;
  logic         w_ovf_set;

  assign w_rise = req_i & ~r_req_q;
  assign w_ack  = r_valid & ack_i;
  assign w_elig = r_pend & ~mask_i;

  always_comb begin
    w_clr = '0;
    if (w_ack) w_clr = N'(onehot(4'(r_code)));
  end

  // A rise on the bit being acked re-arms it instead of counting as overflow.
  assign w_ovf_set = |(w_rise & r_pend & ~w_clr);

  prio_enc_comb #(.N(N), .W(W)) u_enc (
    .i_req   (w_elig),
    .o_code  (w_enc),
    .o_found (w_found)
  );

  // req_q resets to ones so a line already high at reset is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= '1;
      r_pend  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_req_q <= req_i;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clr_ovf_i) r_ovf <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_code  <= w_enc;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack_i) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign code_o  = r_code;
  assign valid_o = r_valid;
  assign pend_o  = r_pend;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_prio_encoder_ctrl.sv
// Directed bench for prio_encoder_ctrl: inputs change and outputs are checked
// on the falling edge, so each step spans exactly one rising edge.
module tb_prio_encoder_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic [N-1:0] mask_i;
  logic         ack_i;
  logic         clr_ovf_i;
  logic [W-1:0] code_o;
  logic         valid_o;
  logic [N-1:0] pend_o;
  logic         ovf_o;

  int n_chk = 0;
  int n_err = 0;

  prio_encoder_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .ack_i     (ack_i),
    .clr_ovf_i (clr_ovf_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] exp_codes [3];
    exp_codes[0] = 3'd6;
    exp_codes[1] = 3'd3;
    exp_codes[2] = 3'd1;

    rst_n = 1'b0; req_i = 8'h04; mask_i = '0; ack_i = 1'b0; clr_ovf_i = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_pend",  32'(pend_o),  0);
    check("rst_code",  32'(code_o),  0);
    check("rst_ovf",   32'(ovf_o),   0);

    // Line held high through reset release must not count as an event.
    rst_n = 1'b1;
    repeat (5) tick();
    check("held_valid", 32'(valid_o), 0);
    check("held_pend",  32'(pend_o),  0);
    req_i = 8'h00;
    tick();

    // Single pulse on bit 5: pend after T, valid after T+1.
    req_i = 8'h20; tick();
    check("p5_pend",   32'(pend_o),  32'h20);
    check("p5_valid0", 32'(valid_o), 0);
    req_i = 8'h00; tick();
    check("p5_valid",  32'(valid_o), 1);
    check("p5_code",   32'(code_o),  5);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("p5_pend_clr", 32'(pend_o),  0);
    check("p5_valid_lo", 32'(valid_o), 0);

    // Ack with nothing presented is ignored.
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("idle_ack_valid", 32'(valid_o), 0);
    check("idle_ack_pend",  32'(pend_o),  0);

    // Bits 1, 3, 6 together: served high to low, one low cycle between.
    req_i = 8'h4A; tick();
    check("multi_pend", 32'(pend_o), 32'h4A);
    req_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("multi_valid", 32'(valid_o), 1);
      check("multi_code",  32'(code_o),  32'(exp_codes[k]));
      ack_i = 1'b1; tick(); ack_i = 1'b0;
      check("multi_gap", 32'(valid_o), 0);
    end
    check("multi_pend_end", 32'(pend_o), 0);

    // Masked bit 7 waits; unmasking mid-presentation does not disturb code 2.
    mask_i = 8'h80; req_i = 8'h84; tick();
    check("mask_pend", 32'(pend_o), 32'h84);
    req_i = 8'h00; tick();
    check("mask_valid", 32'(valid_o), 1);
    check("mask_code",  32'(code_o),  2);
    mask_i = 8'h00; tick();
    check("unmask_hold", 32'(code_o),  2);
    check("unmask_vld",  32'(valid_o), 1);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("mask_gap", 32'(valid_o), 0);
    tick();
    check("unmask_valid", 32'(valid_o), 1);
    check("unmask_code",  32'(code_o),  7);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("unmask_pend_end", 32'(pend_o), 0);

    // Overflow on re-pulse of a pending, non-presented bit.
    req_i = 8'h30; tick();
    req_i = 8'h00; tick();
    check("ovf_pre_code", 32'(code_o), 5);
    check("ovf_pre",      32'(ovf_o),  0);
    req_i = 8'h10; tick();
    check("ovf_set", 32'(ovf_o), 1);
    req_i = 8'h00; tick();
    check("ovf_sticky", 32'(ovf_o), 1);
    clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
    check("ovf_clr", 32'(ovf_o), 0);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick();
    check("b4_valid", 32'(valid_o), 1);
    check("b4_code",  32'(code_o),  4);
    // Re-pulse bit 4 in its own ack cycle: bit survives, no overflow.
    req_i = 8'h10; ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("ackrise_pend",  32'(pend_o),  32'h10);
    check("ackrise_ovf",   32'(ovf_o),   0);
    check("ackrise_valid", 32'(valid_o), 0);
    req_i = 8'h00; tick();
    check("re_valid", 32'(valid_o), 1);
    check("re_code",  32'(code_o),  4);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 0);
    check("arst_pend",  32'(pend_o),  0);
    check("arst_code",  32'(code_o),  0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(valid_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
